// File: rtl/xor_serial_unit.sv
// Bit-serial XOR/XNOR engine: one operand bit per clock, LSB first, built on
// the five-NOR XOR cell. Registered word result and parity under start/busy/done.

module xor_nor_cell (
  input  logic a_i,
  input  logic b_i,
  output logic x_o
);
  logic c_n, a_n, b_n, ab_n;

  nor g_c  (c_n,  a_i, b_i);
  nor g_a  (a_n,  a_i, a_i);
  nor g_b  (b_n,  b_i, b_i);
  nor g_ab (ab_n, a_n, b_n);
  nor g_x  (x_o,  c_n, ab_n);
endmodule

// Handshake: start is sampled only in IDLE and the operands/mode are captured
// on that edge; busy is high for exactly WIDTH cycles, then done pulses for one
// cycle as s/parity update; start in SHIFT or DONE is dropped, never queued.
module xor_serial_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             parity,
  output logic [1:0]       state_dbg
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             parity_q, parity_d;

  logic             x_bit;
  logic             r_bit;
  logic [WIDTH-1:0] r_msb;
  logic [WIDTH-1:0] acc_shift;

  xor_nor_cell u_xor  (.a_i(a_q[0]), .b_i(b_q[0]), .x_o(x_bit));
  // Mode inversion stage: XOR with mode through a second NOR cell.
  xor_nor_cell u_mode (.a_i(x_bit),  .b_i(mode_q), .x_o(r_bit));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      s_q      <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      s_q      <= s_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    s_d      = s_q;
    parity_d = parity_q;

    // Result bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
    r_msb            = '0;
    r_msb[WIDTH-1]   = r_bit;
    acc_shift        = (acc_q >> 1) | r_msb;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d      = acc_shift;
          parity_d = ^acc_shift;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign s         = s_q;
  assign parity    = parity_q;
  assign state_dbg = state_q;
endmodule
